// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the program BRAM read port between instruction fetch (IF) and
// load/debug reads (LS), tracking in-flight reads through a READ_LAT-deep tag pipeline.
module imem_arbiter #(
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    input  logic              ls_req_valid,
    input  logic [ADDR_W-1:0] ls_req_addr,
    output logic              ls_req_ready,
    input  logic              stall,
    input  logic              if_flush,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic [2:0]        inflight
);
    typedef enum logic {REQ_IF = 1'b0, REQ_LS = 1'b1} req_e;

    req_e                pri_q, pri_d;
    logic [READ_LAT-1:0] stg_valid_q, stg_valid_d;
    req_e                stg_id_q [READ_LAT];
    req_e                stg_id_d [READ_LAT];
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [2:0]          inflight_q, inflight_d;
    logic                grant;
    req_e                grant_id;
    logic                last_valid;
    req_e                last_id;

    always_comb begin
        grant    = 1'b0;
        grant_id = pri_q;
        if (!rst && !stall) begin
            if (if_req_valid && ls_req_valid) begin
                grant    = 1'b1;
                grant_id = pri_q;
            end else if (if_req_valid) begin
                grant    = 1'b1;
                grant_id = REQ_IF;
            end else if (ls_req_valid) begin
                grant    = 1'b1;
                grant_id = REQ_LS;
            end
        end

        pri_d      = pri_q;
        mem_addr_d = mem_addr_q;
        if (grant) begin
            pri_d      = (grant_id == REQ_IF) ? REQ_LS : REQ_IF;
            mem_addr_d = (grant_id == REQ_IF) ? if_req_addr : ls_req_addr;
        end
    end

    // A grant in the flush cycle belongs to the new fetch path, so only older IF tags are masked.
    always_comb begin
        stg_valid_d    = '0;
        stg_id_d       = '{default: REQ_IF};
        stg_valid_d[0] = grant;
        stg_id_d[0]    = grant_id;
        for (int unsigned k = 1; k < READ_LAT; k++) begin
            stg_valid_d[k] = stg_valid_q[k-1] && !(if_flush && (stg_id_q[k-1] == REQ_IF));
            stg_id_d[k]    = stg_id_q[k-1];
        end

        inflight_d = '0;
        for (int unsigned k = 0; k < READ_LAT; k++) begin
            inflight_d = inflight_d + 3'(stg_valid_d[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri_q       <= REQ_IF;
            stg_valid_q <= '0;
            stg_id_q    <= '{default: REQ_IF};
            mem_addr_q  <= '0;
            inflight_q  <= '0;
        end else begin
            pri_q       <= pri_d;
            stg_valid_q <= stg_valid_d;
            stg_id_q    <= stg_id_d;
            mem_addr_q  <= mem_addr_d;
            inflight_q  <= inflight_d;
        end
    end

    assign if_req_ready = grant && (grant_id == REQ_IF);
    assign ls_req_ready = grant && (grant_id == REQ_LS);
    assign mem_read_en  = grant;
    assign mem_addr     = mem_addr_d;

    assign last_valid   = stg_valid_q[READ_LAT-1];
    assign last_id      = stg_id_q[READ_LAT-1];
    assign if_rsp_valid = last_valid && (last_id == REQ_IF) && !if_flush;
    assign ls_rsp_valid = last_valid && (last_id == REQ_LS);
    assign if_rsp_data  = mem_q;
    assign ls_rsp_data  = mem_q;
    assign inflight     = inflight_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: table of arbitration vectors, a 2-cycle BRAM model and a
// response scoreboard, plus hand-written reset sequences.
module tb_imem_arbiter;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, ls_req_valid, stall, if_flush;
    logic [31:0] if_req_addr, ls_req_addr;
    logic        if_req_ready, ls_req_ready, mem_read_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_q = '0;
    logic        if_rsp_valid, ls_rsp_valid;
    logic [31:0] if_rsp_data, ls_rsp_data;
    logic [2:0]  inflight;

    always #5 clk = ~clk;

    imem_arbiter #(.READ_LAT(LAT), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_ready(ls_req_ready),
        .stall(stall), .if_flush(if_flush),
        .mem_read_en(mem_read_en), .mem_addr(mem_addr), .mem_q(mem_q),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .inflight(inflight)
    );

    // Program memory contents: word index tagged with a constant pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {16'hC0DE, 5'd0, addr[12:2]};
    endfunction

    logic [31:0] bram_r1 = '0;
    always @(posedge clk) begin
        if (mem_read_en) bram_r1 <= mem_word(mem_addr);
        mem_q <= bram_r1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_ls;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    logic mon_en = 1'b0;

    always @(negedge clk) begin : monitor
        int   n;
        exp_t keep[$];
        exp_t head;
        logic e_if, e_ls;
        if (mon_en && !rst) begin
            n = 0;
            foreach (sbq[i]) if (sbq[i].due <= cyc + LAT - 1) n++;
            check($sformatf("c%0d_inflight", cyc), 32'(inflight), 32'(n));
            if (if_flush) begin
                keep.delete();
                foreach (sbq[i]) if (sbq[i].is_ls) keep.push_back(sbq[i]);
                sbq = keep;
            end
            e_if = 1'b0;
            e_ls = 1'b0;
            head = '{is_ls: 1'b0, data: 32'h0, due: 0};
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                head = sbq.pop_front();
                e_if = !head.is_ls;
                e_ls = head.is_ls;
            end
            check($sformatf("c%0d_if_rsp_valid", cyc), 32'(if_rsp_valid), 32'(e_if));
            check($sformatf("c%0d_ls_rsp_valid", cyc), 32'(ls_rsp_valid), 32'(e_ls));
            if (e_if) check($sformatf("c%0d_if_rsp_data", cyc), if_rsp_data, head.data);
            if (e_ls) check($sformatf("c%0d_ls_rsp_data", cyc), ls_rsp_data, head.data);
            if (if_req_valid && if_req_ready)
                sbq.push_back('{is_ls: 1'b0, data: mem_word(if_req_addr), due: cyc + LAT});
            if (ls_req_valid && ls_req_ready)
                sbq.push_back('{is_ls: 1'b1, data: mem_word(ls_req_addr), due: cyc + LAT});
        end
        cyc++;
    end

    typedef struct {
        logic        stall, ifv, lsv, flush;
        logic [31:0] ifa, lsa;
        logic        e_ifr, e_lsr, e_en;
        logic [31:0] e_addr;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic iv, input logic [31:0] ia,
                                input logic lv, input logic [31:0] la, input logic fl,
                                input logic eir, input logic elr, input logic een,
                                input logic [31:0] ea);
        vec_t v;
        v.stall = st; v.ifv = iv; v.ifa = ia; v.lsv = lv; v.lsa = la; v.flush = fl;
        v.e_ifr = eir; v.e_lsr = elr; v.e_en = een; v.e_addr = ea;
        return v;
    endfunction

    task automatic drive(input logic st, input logic iv, input logic [31:0] ia,
                         input logic lv, input logic [31:0] la, input logic fl);
        stall = st; if_req_valid = iv; if_req_addr = ia;
        ls_req_valid = lv; ls_req_addr = la; if_flush = fl;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_if_ready"}, 32'(if_req_ready), 32'h0);
        check({tag, "_ls_ready"}, 32'(ls_req_ready), 32'h0);
        check({tag, "_read_en"}, 32'(mem_read_en), 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_if_rsp_valid"}, 32'(if_rsp_valid), 32'h0);
        check({tag, "_ls_rsp_valid"}, 32'(ls_rsp_valid), 32'h0);
        check({tag, "_inflight"}, 32'(inflight), 32'h0);
    endtask

    vec_t vecs[$];

    initial begin
        //                 stall ifv ifa        lsv lsa        fl  ifr lsr en  addr
        vecs.push_back(mk(0, 1, 32'h000, 0, 32'h000, 0, 1, 0, 1, 32'h000)); // IF stream
        vecs.push_back(mk(0, 1, 32'h004, 0, 32'h000, 0, 1, 0, 1, 32'h004));
        vecs.push_back(mk(0, 1, 32'h008, 0, 32'h000, 0, 1, 0, 1, 32'h008));
        vecs.push_back(mk(0, 0, 32'h000, 0, 32'h000, 0, 0, 0, 0, 32'h008));
        vecs.push_back(mk(0, 0, 32'h000, 1, 32'h800, 0, 0, 1, 1, 32'h800)); // pri back to IF
        vecs.push_back(mk(0, 1, 32'h010, 1, 32'h800, 0, 1, 0, 1, 32'h010)); // contention
        vecs.push_back(mk(0, 1, 32'h010, 1, 32'h800, 0, 0, 1, 1, 32'h800));
        vecs.push_back(mk(0, 1, 32'h010, 1, 32'h800, 0, 1, 0, 1, 32'h010));
        vecs.push_back(mk(0, 1, 32'h010, 1, 32'h800, 0, 0, 1, 1, 32'h800));
        vecs.push_back(mk(1, 1, 32'h014, 1, 32'h804, 0, 0, 0, 0, 32'h800)); // stall
        vecs.push_back(mk(1, 1, 32'h014, 1, 32'h804, 0, 0, 0, 0, 32'h800));
        vecs.push_back(mk(1, 1, 32'h014, 1, 32'h804, 0, 0, 0, 0, 32'h800));
        vecs.push_back(mk(0, 1, 32'h014, 1, 32'h804, 0, 1, 0, 1, 32'h014));
        vecs.push_back(mk(0, 0, 32'h000, 1, 32'h804, 0, 0, 1, 1, 32'h804));
        vecs.push_back(mk(0, 1, 32'h020, 0, 32'h000, 0, 1, 0, 1, 32'h020)); // flush
        vecs.push_back(mk(0, 1, 32'h024, 0, 32'h000, 0, 1, 0, 1, 32'h024));
        vecs.push_back(mk(0, 1, 32'h100, 0, 32'h000, 1, 1, 0, 1, 32'h100));
        vecs.push_back(mk(0, 0, 32'h000, 0, 32'h000, 0, 0, 0, 0, 32'h100));
        vecs.push_back(mk(0, 0, 32'h000, 0, 32'h000, 0, 0, 0, 0, 32'h100));
        vecs.push_back(mk(0, 1, 32'h030, 0, 32'h000, 0, 1, 0, 1, 32'h030)); // flush with LS
        vecs.push_back(mk(0, 0, 32'h000, 1, 32'h200, 0, 0, 1, 1, 32'h200));
        vecs.push_back(mk(1, 1, 32'h040, 0, 32'h000, 1, 0, 0, 0, 32'h200));
        vecs.push_back(mk(0, 0, 32'h000, 0, 32'h000, 0, 0, 0, 0, 32'h200));
        vecs.push_back(mk(0, 0, 32'h000, 0, 32'h000, 0, 0, 0, 0, 32'h200));

        rst = 1'b1;
        drive(0, 1, 32'h44, 1, 32'h88, 0);
        #12;
        check_quiet("reset");

        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        mon_en = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i].stall, vecs[i].ifv, vecs[i].ifa, vecs[i].lsv, vecs[i].lsa, vecs[i].flush);
            #3;
            check($sformatf("v%0d_if_ready", i), 32'(if_req_ready), 32'(vecs[i].e_ifr));
            check($sformatf("v%0d_ls_ready", i), 32'(ls_req_ready), 32'(vecs[i].e_lsr));
            check($sformatf("v%0d_read_en", i), 32'(mem_read_en), 32'(vecs[i].e_en));
            check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
        end

        // Async reset with two IF tags live.
        @(posedge clk); #1; drive(0, 1, 32'h44, 0, 0, 0);
        @(posedge clk); #1; drive(0, 1, 32'h48, 0, 0, 0);
        @(posedge clk); #1; drive(0, 0, 0, 0, 0, 0);
        #1;
        check("midrst_pre_inflight", 32'(inflight), 32'd2);
        #1;
        rst = 1'b1;
        sbq.delete();
        drive(0, 1, 32'h4C, 1, 32'h90, 0);
        #1;
        check_quiet("midrst");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        drive(0, 1, 32'h50, 1, 32'h900, 0);
        #3;
        check("postrst_if_ready", 32'(if_req_ready), 32'h1);
        check("postrst_ls_ready", 32'(ls_req_ready), 32'h0);
        @(posedge clk); #1; drive(0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        check("final_queue_empty", 32'(sbq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single read port of the 2048-word program BRAM between two requesters: instruction fetch (IF) and the load/debug read path (LS).
- Issues at most one read per cycle, tracks in-flight reads through the BRAM's fixed read latency, and steers returned data to the requester that owns it.
- Sits between the fetch/load units and the BRAM. Supports fetch flush on redirect and a pipeline stall (hazard) that blocks new issue.

Parameters:
- READ_LAT, 2, cycles from mem_read_en asserted to valid mem_q. Sets the depth of the tag pipeline; legal range 1..4.
- ADDR_W, 32, request/memory address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch read request.
- if_req_addr  in  ADDR_W  fetch byte address.
- if_req_ready  out  1  fetch request accepted this cycle.
- ls_req_valid  in  1  load/debug read request.
- ls_req_addr  in  ADDR_W  load byte address.
- ls_req_ready  out  1  load request accepted this cycle.
- stall  in  1  hazard: no grant this cycle.
- if_flush  in  1  discard all in-flight fetch reads.
- mem_read_en  out  1  BRAM read enable.
- mem_addr  out  ADDR_W  BRAM byte address.
- mem_q  in  DATA_W  BRAM read data.
- if_rsp_valid  out  1  fetch data valid.
- if_rsp_data  out  DATA_W  fetch data.
- ls_rsp_valid  out  1  load data valid.
- ls_rsp_data  out  DATA_W  load data.
- inflight  out  3  number of live tags in the pipeline.

Behaviour:
- Reset (async, rst=1):
  - tag pipeline cleared (all stage valid=0).
  - priority pointer pri=IF.
  - All outputs 0 while rst is high: ready, mem_read_en, rsp_valid, inflight; mem_addr=0.
  - A reset mid-operation discards every in-flight read; no response is produced for it after reset releases.
- Arbitration (combinational, same cycle):
  - stall=1: both ready=0, mem_read_en=0.
  - Only one valid: grant it.
  - Both valid: grant the requester named by pri.
  - The granted requester sees ready=1. mem_read_en=1. mem_addr = the granted address, passed unmodified; the BRAM ignores addr[1:0].
  - No grant means mem_read_en=0 and mem_addr holds its previous value (registered copy).
- Priority update: after any grant, pri <= the requester not granted, so a single requester never starves the other. No grant leaves pri unchanged.
- Request handshake: a request is consumed on the cycle valid&ready is seen high. Requesters hold valid and addr stable until ready. Dropping valid before ready is legal (request withdrawn).
- Tag pipeline:
  - READ_LAT stages, each {valid, id}. Stage 0 loads {grant, granted id} every cycle; stage k loads stage k-1.
  - Fully pipelined: back-to-back grants every cycle are legal, with no bubble.
- Response:
  - When the last stage is valid, drive rsp_valid for its id and route mem_q combinationally to that requester's rsp_data, giving zero added latency.
  - The non-owner rsp_valid is 0. Both rsp_data outputs carry mem_q at all times; consumers qualify with rsp_valid.
  - Responses have no backpressure; requesters must accept.
  - End-to-end latency is READ_LAT cycles from the handshake to rsp_valid.
- Flush: if_flush=1 in cycle t clears valid on every stage holding id=IF at the edge ending t. It also suppresses if_rsp_valid combinationally in cycle t.
  - An IF grant in the same cycle t is a new-path fetch. It is NOT killed and enters stage 0.
  - LS tags are unaffected.
  - flush and stall together: flush applies, no grant.
- Ordering: responses return in issue order. Each requester sees its own responses in its request order.
- inflight is the registered count of valid stages, 0..READ_LAT, after flush masking.

Test Plan:
- Reset, then IF-only stream: if_req_valid=1 with addr 0x0,0x4,0x8 on consecutive cycles. Required: if_req_ready=1 each cycle; if_rsp_valid on cycles 2,3,4 with data mem[0],mem[1],mem[2]; ls_rsp_valid stays 0.
- Contention: IF and LS both valid for 4 cycles, addr 0x10 / 0x800. Required: grants IF,LS,IF,LS (pri starts IF); responses alternate in the same order, 2 cycles later.
- Stall: both valid, stall=1 for 3 cycles. Required: ready=0, mem_read_en=0, inflight decays to 0. On release, IF is granted first if pri=IF.
- Flush: IF reads at 0x20 and 0x24 are issued, then if_flush=1 in the next cycle together with an IF request at 0x100. Required: no if_rsp_valid for 0x20 or 0x24; mem[0x40] is returned 2 cycles after the flush cycle; an in-flight LS read is still delivered.
- Async reset mid-flight: assert rst between clock edges with 2 tags live. Required: outputs go 0 immediately, inflight=0, and no rsp_valid after deassert until new requests are made.
- Mixed flush with LS: LS read at 0x200 in flight, flush asserted. Required: ls_rsp_valid with mem[0x80] on schedule, and inflight drops by only the IF count.
